uart_rx: RTL

- UART receiver, the receive-side counterpart of the team's 8N1 transmitter `tx`.
- Takes the asynchronous serial line `rx` and synchronizes it into the `clock` domain.
- Recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop) by mid-bit sampling.
- Presents each received byte with a one-cycle valid strobe and flags framing errors. Sits between the board pin and byte-level consumer logic.

---
 rtl/uart_pkg.sv | 17 +
 rtl/sync_2ff.sv | 26 ++
 rtl/uart_rx.sv | 128 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and default baud setup
// common to both ends of the link.
package uart_pkg;

  localparam int DATA_BITS     = 8;
  localparam int CLK_FREQ_DEF  = 100_000_000;
  localparam int BAUD_RATE_DEF = 9600;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; both flops reset to RESET_VAL.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes rx, samples each bit at its middle and emits one-cycle
// valid / framing-error strobes.
//
//   state     | meaning
//   IDLE      | line idle, waiting for a low level (start bit)
//   START     | half-bit delay, then confirm start bit is still low
//   DATA      | sample 8 data bits, one per bit period, LSB first
//   STOP      | sample stop bit; 1 -> deliver byte, 0 -> framing error
//   WAIT_IDLE | after a framing error, wait for the line to return high
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = CLK_FREQ_DEF,
  parameter int BAUD_RATE = BAUD_RATE_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int BIT_W        = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(HALF_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

  logic                 rx_s;
  state_t               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [BIT_W-1:0]     bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 valid_q;
  logic                 err_q;
  logic                 busy_q;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk_i  (clock),
    .rst_ni (reset),
    .d_i    (rx),
    .q_o    (rx_s)
  );

  // cnt_q is a down-counter; a sample is taken on the cycle it reaches zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      rx_data_q <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_q <= START;
            cnt_q   <= HALF_LOAD;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (rx_s) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= DATA;
            cnt_q   <= BIT_LOAD;
            bit_q   <= '0;
          end
        end
        DATA: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
            cnt_q   <= BIT_LOAD;
            if (bit_q == LAST_BIT) begin
              state_q <= STOP;
              bit_q   <= '0;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end
        end
        STOP: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            busy_q <= 1'b0;
            // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge.
            if (rx_s) begin
              rx_data_q <= shift_q;
              valid_q   <= 1'b1;
              state_q   <= IDLE;
            end else begin
              err_q   <= 1'b1;
              state_q <= WAIT_IDLE;
            end
          end
        end
        WAIT_IDLE: begin
          if (rx_s) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = valid_q;
  assign rx_frame_err = err_q;
  assign rx_busy      = busy_q;

endmodule
